bus_ram: RTL and testbench
==========================

Name: bus_ram

Overview:
- Word-organised on-chip RAM target on the core's shared memory bus.
- Sits directly downstream of the core bus arbiter and consumes its rd/wr/addr/wrmask/data request.
- Returns the rd_valid/wr_valid/data response the arbiter routes back to fetch or load/store.
- Adds configurable wait states, byte-masked writes, request abort and out-of-range error reporting.

Parameters:
DEPTH_WORDS  1024  number of 32-bit words; power of two, >= 2
BASE_ADDR  32'h0000_0000  byte address of word 0; aligned to DEPTH_WORDS*4
LATENCY  1  wait cycles between accept and response; 0..15 allowed

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
i_bus_rd  input  1  read request, level, held by requester until o_bus_rd_valid
i_bus_wr  input  1  write request, level, held by requester until o_bus_wr_valid
i_bus_addr  input  32  byte address; bits [1:0] ignored
i_bus_wrmask  input  4  byte enables; bit n writes byte lane n (data[8n+7:8n])
i_bus_data  input  32  write data
o_bus_rd_valid  output  1  one-cycle read-complete pulse
o_bus_wr_valid  output  1  one-cycle write-complete pulse
o_bus_data  output  32  read data; valid only while o_bus_rd_valid=1, else 0
o_bus_err  output  1  one-cycle pulse alongside a valid when the access was out of range

Behaviour:
- Reset:
  - state=IDLE; all outputs 0; latched request cleared.
  - RAM contents are not reset.
  - Reset asserted mid-operation abandons the access: no pulse, pending write not committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Any cycle with i_bus_rd|i_bus_wr high is a new request; it is accepted that cycle.
  - Accept latches kind, word index, mask and data.
  - rd and wr both high: read wins (arbiter never drives both).
  - Next state is WAIT if LATENCY>0, else RESP.
- WAIT:
  - Down-counter loaded with LATENCY-1 at accept; on count==0 -> RESP.
  - Abort: if i_bus_rd and i_bus_wr are both low in WAIT -> IDLE next cycle, no pulse, no write.
  - Changes to address or data in WAIT are ignored; latched values are used.
- RESP (exactly one cycle, then always IDLE):
  - Read: o_bus_rd_valid=1; o_bus_data=mem[latched index], registered on entry to RESP.
  - Write: o_bus_wr_valid=1; masked bytes committed at the clock edge ending RESP.
  - Unmasked bytes are unchanged; mask 4'b0000 still completes with no change.
  - Abort is not checked in RESP: a response is always delivered once RESP is reached.
- Latency:
  - Request accepted in cycle T -> valid pulse in cycle T+1+LATENCY.
  - IDLE always follows RESP, so back-to-back requests complete every LATENCY+2 cycles.
  - A request still high in the IDLE cycle after RESP is treated as a new access.
- Range:
  - In range iff BASE_ADDR <= addr <= BASE_ADDR+DEPTH_WORDS*4-1 (unsigned, 32-bit compare, no overflow).
  - In-range index = (addr-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits.
  - Out of range, read: completes normally with o_bus_data=0 and o_bus_err=1.
  - Out of range, write: completes with o_bus_wr_valid=1 and o_bus_err=1; nothing written.
- Read-after-write to the same word returns the new data; sequencing through IDLE guarantees this.
- Memory is a single-port synchronous array; at most one access per cycle. The style must infer block RAM: no reset on the array, byte-enable write.

Test Plan:
1. LATENCY=1: write 0xA5A5_1234 mask 4'hF to addr 0x10 in cycle 0 -> o_bus_wr_valid only in cycle 2. Then read addr 0x10 -> o_bus_rd_valid with data 0xA5A5_1234 exactly 2 cycles after accept, err=0.
2. Byte mask: preload 0x1122_3344 at 0x20; write 0xFFFF_FFFF mask 4'b0101 -> read returns 0x11FF_33FF. Mask 4'b0000 -> wr_valid pulses, word unchanged.
3. Range, BASE_ADDR=0x1000, DEPTH_WORDS=16:
   - Read 0x103C -> err=0.
   - Read 0x1040 and 0x0FFC -> rd_valid=1, data=0, err=1.
   - Write 0x1040 -> err=1; no word in RAM modified.
4. Abort, LATENCY=4: accept write to 0x8, drop i_bus_wr in cycle 2 -> no valid pulses, FSM in IDLE at cycle 3, word 0x8 unchanged. Read abort behaves the same.
5. Back-to-back with LATENCY=0: hold i_bus_rd high with addr stepping 0x0, 0x4, 0x8 as each valid arrives -> pulses in cycles 1, 3, 5 with correct data. Sweep LATENCY=0, 3, 15 and check T+1+LATENCY each time.
6. Reset mid-write: assert rst during WAIT -> outputs 0 immediately, no wr_valid, word not modified. After release, a new read is served normally.

Source files
------------

// File: rtl/bus_ram.sv
// Word-organised RAM target on the shared memory bus.
// Supports configurable wait states, byte-masked writes, request abort and out-of-range error pulses.
//
// state | meaning
// IDLE  | waiting for rd/wr; a request seen here is accepted and latched
// WAIT  | LATENCY wait cycles counting down; rd and wr both low aborts
// RESP  | one-cycle response pulse; write data committed at the end of it
module bus_ram #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned LATENCY     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_bus_rd,
   input  logic        i_bus_wr,
   input  logic [31:0] i_bus_addr,
   input  logic [3:0]  i_bus_wrmask,
   input  logic [31:0] i_bus_data,
   output logic        o_bus_rd_valid,
   output logic        o_bus_wr_valid,
   output logic [31:0] o_bus_data,
   output logic        o_bus_err
);

   localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
   localparam logic [3:0]  CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic            req_is_wr;
   logic            req_in_range;
   logic [AW-1:0]   req_idx;
   logic [3:0]      req_mask;
   logic [31:0]     req_data;
   logic [3:0]      cnt;

   logic [31:0]     mem [DEPTH_WORDS];
   logic [31:0]     rd_data;

   logic            accept;
   logic            new_in_range;
   logic [AW-1:0]   new_idx;
   logic            mem_rd_en;
   logic [AW-1:0]   mem_rd_idx;
   logic            mem_we;

   assign accept       = (state == IDLE) && (i_bus_rd || i_bus_wr);
   // 33-bit compare so a window ending at the top of the address space cannot wrap
   assign new_in_range = ({1'b0, i_bus_addr} >= {1'b0, BASE_ADDR}) &&
                         ({1'b0, i_bus_addr} <  END_ADDR);
   assign new_idx      = AW'((i_bus_addr - BASE_ADDR) >> 2);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) state_nxt = (LATENCY == 0) ? RESP : WAIT;
         end
         WAIT: begin
            if (!i_bus_rd && !i_bus_wr) state_nxt = IDLE;
            else if (cnt == 4'd0)       state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // With zero latency the read launches in the accept cycle, before the index is latched
   assign mem_rd_en  = (state_nxt == RESP);
   assign mem_rd_idx = (state == IDLE) ? new_idx : req_idx;
   assign mem_we     = (state == RESP) && req_is_wr && req_in_range;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         req_is_wr    <= 1'b0;
         req_in_range <= 1'b0;
         req_idx      <= '0;
         req_mask     <= 4'd0;
         req_data     <= 32'd0;
         cnt          <= 4'd0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            req_is_wr    <= !i_bus_rd;
            req_in_range <= new_in_range;
            req_idx      <= new_idx;
            req_mask     <= i_bus_wrmask;
            req_data     <= i_bus_data;
            cnt          <= CNT_LOAD;
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_rd_en) rd_data <= mem[mem_rd_idx];
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (req_mask[b]) mem[req_idx][8*b +: 8] <= req_data[8*b +: 8];
         end
      end
   end

   assign o_bus_rd_valid = (state == RESP) && !req_is_wr;
   assign o_bus_wr_valid = (state == RESP) &&  req_is_wr;
   assign o_bus_err      = (state == RESP) && !req_in_range;
   assign o_bus_data     = (o_bus_rd_valid && req_in_range) ? rd_data : 32'd0;

endmodule

// File: tb/tb_bus_ram.sv
// Bench for bus_ram: six instances with different latency/range settings checked
// against an array-based memory model with timing derived from LATENCY.
module tb_bus_ram;

   localparam int N = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd       [N];
   logic        wr       [N];
   logic [31:0] addr     [N];
   logic [3:0]  mask     [N];
   logic [31:0] wdata    [N];
   logic        rd_valid [N];
   logic        wr_valid [N];
   logic [31:0] rdata    [N];
   logic        err      [N];

   int     lat_c   [N] = '{1, 4, 0, 3, 15, 1};
   longint base_c  [N] = '{0, 0, 0, 0, 0, 'h1000};
   longint depth_c [N] = '{1024, 1024, 1024, 1024, 1024, 16};

   logic [31:0] mdl [N][1024];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      bus_ram #(
         .DEPTH_WORDS(g == 5 ? 16 : 1024),
         .BASE_ADDR  (g == 5 ? 32'h1000 : 32'h0),
         .LATENCY    (g == 0 ? 1 : g == 1 ? 4 : g == 2 ? 0 : g == 3 ? 3 : g == 4 ? 15 : 1)
      ) u_dut (
         .clk           (clk),
         .rst           (rst),
         .i_bus_rd      (rd[g]),
         .i_bus_wr      (wr[g]),
         .i_bus_addr    (addr[g]),
         .i_bus_wrmask  (mask[g]),
         .i_bus_data    (wdata[g]),
         .o_bus_rd_valid(rd_valid[g]),
         .o_bus_wr_valid(wr_valid[g]),
         .o_bus_data    (rdata[g]),
         .o_bus_err     (err[g])
      );
   end

   // ---------------- reference model ----------------
   function automatic bit in_rng(int d, logic [31:0] a);
      longint la = longint'({32'd0, a});
      return (la >= base_c[d]) && (la < base_c[d] + 4 * depth_c[d]);
   endfunction

   function automatic int widx(int d, logic [31:0] a);
      return int'((longint'({32'd0, a}) - base_c[d]) / 4);
   endfunction

   function automatic logic [31:0] model_read(int d, logic [31:0] a);
      if (!in_rng(d, a)) return 32'd0;
      return mdl[d][widx(d, a)];
   endfunction

   task automatic model_write(int d, logic [31:0] a, logic [3:0] m, logic [31:0] v);
      logic [31:0] w;
      if (!in_rng(d, a)) return;
      w = mdl[d][widx(d, a)];
      for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = v[8*b +: 8];
      mdl[d][widx(d, a)] = w;
   endtask

   // Drives one request and reports what came back; latency counted from the accept cycle.
   task automatic access(input int d, input bit is_wr, input logic [31:0] a, input logic [3:0] m,
                         input logic [31:0] v, output int lat, output bit g_rd, output bit g_wr,
                         output bit g_err, output logic [31:0] g_data, output bit extra);
      @(negedge clk);
      rd[d] = !is_wr; wr[d] = is_wr; addr[d] = a; mask[d] = m; wdata[d] = v;
      lat = -1; g_rd = 0; g_wr = 0; g_err = 0; g_data = 32'hx;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (rd_valid[d] || wr_valid[d]) begin
            lat = n; g_rd = rd_valid[d]; g_wr = wr_valid[d]; g_err = err[d]; g_data = rdata[d];
            break;
         end
      end
      rd[d] = 0; wr[d] = 0;
      @(negedge clk);
      extra = rd_valid[d] || wr_valid[d];
   endtask

   // Writes through the DUT and the model; used for setting up known contents.
   task automatic preload(int d, logic [31:0] a, logic [31:0] v);
      int lat; bit grd, gwr, gerr, ex; logic [31:0] gd;
      access(d, 1, a, 4'hF, v, lat, grd, gwr, gerr, gd, ex);
      model_write(d, a, 4'hF, v);
      checks++;
      if (lat != 1 + lat_c[d] || !gwr) begin
         errors++;
         $display("FAIL preload dut%0d addr %h: lat %0d wr_valid %0b, want lat %0d wr_valid 1",
                  d, a, lat, gwr, 1 + lat_c[d]);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1;
      for (int d = 0; d < N; d++) begin
         rd[d] = 0; wr[d] = 0; addr[d] = 0; mask[d] = 0; wdata[d] = 0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < N; d++) begin
         checks++;
         if ({rd_valid[d], wr_valid[d], err[d], rdata[d]} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs dut%0d: rdv %b wrv %b err %b data %h, want all 0",
                     d, rd_valid[d], wr_valid[d], err[d], rdata[d]);
         end
      end
      rst = 0;
   endtask

   task automatic test_basic();
      int lat; bit grd, gwr, gerr, ex; logic [31:0] gd;
      access(0, 1, 32'h10, 4'hF, 32'hA5A5_1234, lat, grd, gwr, gerr, gd, ex);
      model_write(0, 32'h10, 4'hF, 32'hA5A5_1234);
      checks++;
      if (lat != 2 || !gwr || grd || gerr || ex) begin
         errors++;
         $display("FAIL basic_write: lat %0d wrv %b rdv %b err %b extra %b, want 2 1 0 0 0",
                  lat, gwr, grd, gerr, ex);
      end
      access(0, 0, 32'h10, 4'h0, 32'h0, lat, grd, gwr, gerr, gd, ex);
      checks++;
      if (lat != 2 || !grd || gwr || gerr || ex || gd !== model_read(0, 32'h10)) begin
         errors++;
         $display("FAIL basic_read: lat %0d rdv %b err %b extra %b data %h, want 2 1 0 0 %h",
                  lat, grd, gerr, ex, gd, model_read(0, 32'h10));
      end
   endtask

   task automatic test_byte_mask();
      int lat; bit grd, gwr, gerr, ex; logic [31:0] gd;
      preload(0, 32'h20, 32'h1122_3344);
      access(0, 1, 32'h20, 4'b0101, 32'hFFFF_FFFF, lat, grd, gwr, gerr, gd, ex);
      model_write(0, 32'h20, 4'b0101, 32'hFFFF_FFFF);
      access(0, 0, 32'h20, 4'h0, 32'h0, lat, grd, gwr, gerr, gd, ex);
      checks++;
      if (gd !== model_read(0, 32'h20) || gd !== 32'h11FF_33FF || !grd) begin
         errors++;
         $display("FAIL mask_0101: data %h rdv %b, want %h", gd, grd, model_read(0, 32'h20));
      end
      access(0, 1, 32'h20, 4'b0000, 32'hDEAD_BEEF, lat, grd, gwr, gerr, gd, ex);
      checks++;
      if (lat != 2 || !gwr || gerr) begin
         errors++;
         $display("FAIL mask_0000_complete: lat %0d wrv %b err %b, want 2 1 0", lat, gwr, gerr);
      end
      access(0, 0, 32'h20, 4'h0, 32'h0, lat, grd, gwr, gerr, gd, ex);
      checks++;
      if (gd !== model_read(0, 32'h20)) begin
         errors++;
         $display("FAIL mask_0000_nochange: data %h, want %h", gd, model_read(0, 32'h20));
      end
   endtask

   task automatic test_range();
      int lat; bit grd, gwr, gerr, ex; logic [31:0] gd;
      logic [31:0] oor [2] = '{32'h1040, 32'h0FFC};
      for (int i = 0; i < 16; i++) preload(5, 32'h1000 + 4 * i, $urandom);
      access(5, 0, 32'h103C, 4'h0, 32'h0, lat, grd, gwr, gerr, gd, ex);
      checks++;
      if (!grd || gerr || gd !== model_read(5, 32'h103C)) begin
         errors++;
         $display("FAIL range_last_word: rdv %b err %b data %h, want 1 0 %h",
                  grd, gerr, gd, model_read(5, 32'h103C));
      end
      for (int i = 0; i < 2; i++) begin
         access(5, 0, oor[i], 4'h0, 32'h0, lat, grd, gwr, gerr, gd, ex);
         checks++;
         if (!grd || !gerr || gd !== 32'd0 || lat != 2) begin
            errors++;
            $display("FAIL range_oor_read %h: rdv %b err %b data %h lat %0d, want 1 1 0 2",
                     oor[i], grd, gerr, gd, lat);
         end
      end
      access(5, 1, 32'h1040, 4'hF, 32'h0BAD_0BAD, lat, grd, gwr, gerr, gd, ex);
      model_write(5, 32'h1040, 4'hF, 32'h0BAD_0BAD);
      checks++;
      if (!gwr || !gerr || lat != 2) begin
         errors++;
         $display("FAIL range_oor_write: wrv %b err %b lat %0d, want 1 1 2", gwr, gerr, lat);
      end
      for (int i = 0; i < 16; i++) begin
         access(5, 0, 32'h1000 + 4 * i, 4'h0, 32'h0, lat, grd, gwr, gerr, gd, ex);
         checks++;
         if (gd !== model_read(5, 32'h1000 + 4 * i) || gerr) begin
            errors++;
            $display("FAIL range_untouched word %0d: data %h err %b, want %h 0",
                     i, gd, gerr, model_read(5, 32'h1000 + 4 * i));
         end
      end
   endtask

   task automatic test_abort();
      int wr_pulses, rd_cyc, pulses, lat;
      bit grd, gwr, gerr, ex;
      logic [31:0] rd_dat, gd;
      preload(1, 32'h8, 32'h0808_0808);
      // write abort: accept in cycle 0, request low during cycle 2
      @(negedge clk);
      wr[1] = 1; addr[1] = 32'h8; mask[1] = 4'hF; wdata[1] = 32'h5555_AAAA;
      @(posedge clk);
      @(posedge clk);
      #1 wr[1] = 0;
      @(posedge clk);
      #1 rd[1] = 1;
      wr_pulses = 0; rd_cyc = -1; rd_dat = 32'hx;
      for (int c = 3; c <= 15; c++) begin
         @(negedge clk);
         if (wr_valid[1]) wr_pulses++;
         if (rd_valid[1] && rd_cyc < 0) begin
            rd_cyc = c; rd_dat = rdata[1]; rd[1] = 0;
         end
      end
      rd[1] = 0;
      checks++;
      if (wr_pulses != 0 || rd_cyc != 3 + 1 + lat_c[1] || rd_dat !== model_read(1, 32'h8)) begin
         errors++;
         $display("FAIL abort_write: wr pulses %0d read cycle %0d data %h, want 0 %0d %h",
                  wr_pulses, rd_cyc, rd_dat, 3 + 1 + lat_c[1], model_read(1, 32'h8));
      end
      // read abort
      @(negedge clk);
      rd[1] = 1; addr[1] = 32'h8;
      @(posedge clk);
      @(posedge clk);
      #1 rd[1] = 0;
      pulses = 0;
      for (int c = 2; c <= 12; c++) begin
         @(negedge clk);
         if (rd_valid[1] || wr_valid[1] || err[1]) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL abort_read: %0d pulse cycles, want 0", pulses);
      end
      access(1, 0, 32'h8, 4'h0, 32'h0, lat, grd, gwr, gerr, gd, ex);
      checks++;
      if (lat != 1 + lat_c[1] || gd !== model_read(1, 32'h8)) begin
         errors++;
         $display("FAIL abort_recover: lat %0d data %h, want %0d %h",
                  lat, gd, 1 + lat_c[1], model_read(1, 32'h8));
      end
   endtask

   task automatic test_back_to_back(int d);
      int L, k;
      int pc [3];
      logic [31:0] pd [3];
      L = lat_c[d];
      for (int i = 0; i < 3; i++) preload(d, 4 * i, $urandom);
      for (int i = 0; i < 3; i++) begin pc[i] = -1; pd[i] = 32'hx; end
      k = 0;
      @(negedge clk);
      rd[d] = 1; addr[d] = 32'h0;
      for (int c = 1; c <= 3 * (L + 2) + 5; c++) begin
         @(negedge clk);
         if (rd_valid[d] && k < 3) begin
            pc[k] = c; pd[k] = rdata[d]; k++;
            if (k < 3) addr[d] = 4 * k;
            else rd[d] = 0;
         end
      end
      rd[d] = 0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (pc[i] != i * (L + 2) + 1 + L || pd[i] !== model_read(d, 4 * i)) begin
            errors++;
            $display("FAIL b2b L=%0d pulse %0d: cycle %0d data %h, want %0d %h",
                     L, i, pc[i], pd[i], i * (L + 2) + 1 + L, model_read(d, 4 * i));
         end
      end
   endtask

   task automatic test_reset_mid();
      int lat, wr_seen;
      bit grd, gwr, gerr, ex, seen;
      logic [31:0] gd;
      preload(1, 32'h30, 32'h3030_3030);
      @(negedge clk);
      wr[1] = 1; addr[1] = 32'h30; mask[1] = 4'hF; wdata[1] = 32'hFEED_FACE;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1;
      #1;
      checks++;
      if ({rd_valid[1], wr_valid[1], err[1], rdata[1]} !== 35'd0) begin
         errors++;
         $display("FAIL reset_wait_outputs: rdv %b wrv %b err %b data %h, want 0",
                  rd_valid[1], wr_valid[1], err[1], rdata[1]);
      end
      wr_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (wr_valid[1]) wr_seen++;
      end
      wr[1] = 0;
      rst = 0;
      repeat (8) begin
         @(negedge clk);
         if (wr_valid[1]) wr_seen++;
      end
      checks++;
      if (wr_seen != 0) begin
         errors++;
         $display("FAIL reset_no_wr_valid: %0d pulses, want 0", wr_seen);
      end
      access(1, 0, 32'h30, 4'h0, 32'h0, lat, grd, gwr, gerr, gd, ex);
      checks++;
      if (lat != 1 + lat_c[1] || !grd || gd !== model_read(1, 32'h30)) begin
         errors++;
         $display("FAIL reset_then_read: lat %0d rdv %b data %h, want %0d 1 %h",
                  lat, grd, gd, 1 + lat_c[1], model_read(1, 32'h30));
      end
      // reset landing in the response cycle must clear the pulse at once
      preload(0, 32'h40, 32'h4444_4444);
      @(negedge clk);
      rd[0] = 1; addr[0] = 32'h40;
      seen = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (rd_valid[0]) begin seen = 1; break; end
      end
      rst = 1;
      #1;
      checks++;
      if (!seen || rd_valid[0] !== 1'b0 || rdata[0] !== 32'd0) begin
         errors++;
         $display("FAIL reset_in_resp: pulse seen %b rdv %b data %h, want 1 0 0",
                  seen, rd_valid[0], rdata[0]);
      end
      rd[0] = 0;
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_random(int d);
      int lat; bit grd, gwr, gerr, ex, is_wr;
      logic [31:0] gd, a, v, exp_d;
      logic [3:0] m;
      for (int i = 0; i < 32; i++) preload(d, 4 * i, $urandom);
      for (int i = 0; i < 40; i++) begin
         is_wr = bit'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) a = 32'h1000 + $urandom_range(0, 32'h0FFF_FFFF);
         else a = 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
         m = 4'($urandom_range(0, 15));
         v = $urandom;
         exp_d = model_read(d, a);
         access(d, is_wr, a, m, v, lat, grd, gwr, gerr, gd, ex);
         if (is_wr) model_write(d, a, m, v);
         checks++;
         if (lat != 1 + lat_c[d] || grd != !is_wr || gwr != is_wr || gerr != !in_rng(d, a) || ex) begin
            errors++;
            $display("FAIL random dut%0d op %0d addr %h: lat %0d rdv %b wrv %b err %b extra %b, want %0d %b %b %b 0",
                     d, i, a, lat, grd, gwr, gerr, ex, 1 + lat_c[d], !is_wr, is_wr, !in_rng(d, a));
         end
         if (!is_wr) begin
            checks++;
            if (gd !== exp_d) begin
               errors++;
               $display("FAIL random_data dut%0d op %0d addr %h: data %h, want %h", d, i, a, gd, exp_d);
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_byte_mask();
      test_range();
      test_abort();
      test_back_to_back(2);
      test_back_to_back(3);
      test_back_to_back(4);
      test_reset_mid();
      test_random(0);
      test_random(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
